// File: rtl/lsu_pkg.sv
// Shared types and helpers for the data-memory access sequencer.
// Holds the FSM state type, access-size codes and the alignment check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } dmc_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size code 2'b11 is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = a[0];
            default: mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/grant/read-valid bus between the access sequencer and memory.
interface dmem_access_ctrl_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: byte enables and replicated store data
// for the addressed lanes of a 32-bit word.
module dmem_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh
);

    always_comb begin
        be       = 4'b1111;
        wdata_sh = wdata;
        case (size)
            SZ_BYTE: begin
                be       = 4'b0001 << addr_lo;
                wdata_sh = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                wdata_sh = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer: one access at a time over a req/gnt/rvalid bus,
// stalling the pipeline until the access completes, times out or is rejected as misaligned.
module dmem_access_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_req,
    input  logic                   mem_we,
    input  logic [1:0]             mem_size,
    input  logic                   mem_unsigned,
    input  logic [31:0]            mem_addr,
    input  logic [31:0]            mem_wdata,
    output logic                   stall,
    output logic                   done,
    output logic                   misalign_err,
    output logic                   bus_err,
    dmem_access_ctrl_if.master     dm,
    output logic [1:0]             ld_l_sel,
    output logic [1:0]             ld_bhw_sel,
    output logic                   ld_u_load,
    output logic [31:0]            ld_raw_data
);

    dmc_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             dm_req_q;
    logic             dm_we_q;
    logic [31:0]      dm_addr_q;
    logic [3:0]       dm_be_q;
    logic [31:0]      dm_wdata_q;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic             mis;
    logic [1:0]       size_norm;

    dmem_lane_align u_lane_align (
        .size     (mem_size),
        .addr_lo  (mem_addr[1:0]),
        .wdata    (mem_wdata),
        .be       (st_be),
        .wdata_sh (st_wdata)
    );

    assign mis       = is_misaligned(mem_size, mem_addr[1:0]);
    assign size_norm = (mem_size == 2'b11) ? SZ_WORD : mem_size;

    // The requesting IDLE cycle is frozen combinationally; DONE releases the pipeline.
    assign stall = (state == REQ) || (state == WAIT) || ((state == IDLE) && mem_req);
    assign done  = (state == DONE);

    assign dm.dm_req   = dm_req_q;
    assign dm.dm_we    = dm_we_q;
    assign dm.dm_addr  = dm_addr_q;
    assign dm.dm_be    = dm_be_q;
    assign dm.dm_wdata = dm_wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            dm_req_q     <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= '0;
            dm_be_q      <= '0;
            dm_wdata_q   <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            ld_l_sel     <= '0;
            ld_bhw_sel   <= '0;
            ld_u_load    <= 1'b0;
            ld_raw_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        ld_l_sel   <= size_norm;
                        ld_bhw_sel <= mem_addr[1:0];
                        ld_u_load  <= mem_unsigned;
                        if (mis) begin
                            misalign_err <= 1'b1;
                            state        <= DONE;
                        end else begin
                            dm_req_q   <= 1'b1;
                            dm_we_q    <= mem_we;
                            dm_addr_q  <= {mem_addr[31:2], 2'b00};
                            dm_be_q    <= mem_we ? st_be : 4'b1111;
                            dm_wdata_q <= st_wdata;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dm.dm_gnt) begin
                        dm_req_q <= 1'b0;
                        if (dm_we_q) begin
                            state <= DONE;
                        end else if (dm.dm_rvalid) begin
                            ld_raw_data <= dm.dm_rdata;
                            state       <= DONE;
                        end else begin
                            wait_cnt <= '0;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A response arriving on the final counted cycle still wins over the timeout.
                    if (dm.dm_rvalid) begin
                        ld_raw_data <= dm.dm_rdata;
                        state       <= DONE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus_err     <= 1'b1;
                        ld_raw_data <= '0;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    misalign_err <= 1'b0;
                    bus_err      <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with an 8-cycle response timeout.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic        done;
    logic        misalign_err;
    logic        bus_err;
    logic [1:0]  ld_l_sel;
    logic [1:0]  ld_bhw_sel;
    logic        ld_u_load;
    logic [31:0] ld_raw_data;

    int total = 0;
    int bad   = 0;
    int n_stall;
    int done_c;
    int req_seen;

    dmem_access_ctrl_if dm_bus ();

    dmem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .stall        (stall),
        .done         (done),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .dm           (dm_bus),
        .ld_l_sel     (ld_l_sel),
        .ld_bhw_sel   (ld_bhw_sel),
        .ld_u_load    (ld_u_load),
        .ld_raw_data  (ld_raw_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Cycle 0 is the IDLE cycle that raises mem_req; returns after sampling the done cycle.
    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gnt_c, input int rv_c, input logic [31:0] rdata);
        bit fin;
        fin      = 1'b0;
        n_stall  = 0;
        done_c   = -1;
        req_seen = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            mem_req          = 1'b1;
            mem_we           = we;
            mem_size         = size;
            mem_unsigned     = uns;
            mem_addr         = addr;
            mem_wdata        = wd;
            dm_bus.dm_gnt    = (c == gnt_c);
            dm_bus.dm_rvalid = (c == rv_c);
            dm_bus.dm_rdata  = (c == rv_c) ? rdata : 32'hBAD0BAD0;
            #1;
            if (stall) n_stall++;
            if (dm_bus.dm_req) req_seen = 1;
            if (done) begin
                done_c = c;
                fin    = 1'b1;
            end
        end
        if (!fin) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        mem_req          = 1'b0;
        dm_bus.dm_gnt    = 1'b0;
        dm_bus.dm_rvalid = 1'b0;
        #1;
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_idle_flags"}, {30'd0, misalign_err, bus_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst_n            = 1'b0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_size         = 2'b00;
        mem_unsigned     = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        dm_bus.dm_gnt    = 1'b0;
        dm_bus.dm_rvalid = 1'b0;
        dm_bus.dm_rdata  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ctrl", {28'd0, stall, done, misalign_err, bus_err}, 32'd0);
        chk("rst_dm", {27'd0, dm_bus.dm_req, dm_bus.dm_be}, 32'd0);
        chk("rst_addr", dm_bus.dm_addr, 32'd0);
        chk("rst_ld", {27'd0, ld_l_sel, ld_bhw_sel, ld_u_load}, 32'd0);
        chk("rst_raw", ld_raw_data, 32'd0);

        // LW 0x100, grant cycle 1, data three cycles later
        access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1, 4, 32'hDEADBEEF);
        chk("lw_stalls", n_stall, 5);
        chk("lw_done_c", done_c, 5);
        chk("lw_raw", ld_raw_data, 32'hDEADBEEF);
        chk("lw_lsel", ld_l_sel, 2'b10);
        chk("lw_addr", dm_bus.dm_addr, 32'h100);
        chk("lw_be", dm_bus.dm_be, 4'b1111);
        idle_cycle("lw");

        // SB 0x203, grant immediately
        access(1'b1, 2'b00, 1'b0, 32'h203, 32'h000000A5, 1, -1, 32'h0);
        chk("sb_done_c", done_c, 2);
        chk("sb_stalls", n_stall, 2);
        chk("sb_be", dm_bus.dm_be, 4'b1000);
        chk("sb_wdata", dm_bus.dm_wdata, 32'hA5A5A5A5);
        chk("sb_we", dm_bus.dm_we, 1'b1);
        chk("sb_addr", dm_bus.dm_addr, 32'h200);
        idle_cycle("sb");

        // SH 0x102 with delayed grant
        access(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000BEEF, 2, -1, 32'h0);
        chk("sh_done_c", done_c, 3);
        chk("sh_be", dm_bus.dm_be, 4'b1100);
        chk("sh_wdata", dm_bus.dm_wdata, 32'hBEEFBEEF);
        idle_cycle("sh");

        // LH 0x102
        access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1, 1, 32'h12345678);
        chk("lh_be", dm_bus.dm_be, 4'b1111);
        chk("lh_bhw", ld_bhw_sel, 2'b10);
        chk("lh_lsel", ld_l_sel, 2'b01);
        chk("lh_done_c", done_c, 2);
        idle_cycle("lh");

        // LW 0x101 misaligned
        access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1, 1, 32'h0);
        chk("mis_done_c", done_c, 1);
        chk("mis_err", misalign_err, 1'b1);
        chk("mis_req", req_seen, 0);
        chk("mis_berr", bus_err, 1'b0);
        idle_cycle("mis");

        // LBU 0x3, zero-wait memory
        access(1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 1, 1, 32'h80FF0000);
        chk("lbu_u", ld_u_load, 1'b1);
        chk("lbu_bhw", ld_bhw_sel, 2'b11);
        chk("lbu_done_c", done_c, 2);
        chk("lbu_raw", ld_raw_data, 32'h80FF0000);
        chk("lbu_lsel", ld_l_sel, 2'b00);
        idle_cycle("lbu");

        // Size code 11 behaves as a word
        access(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 1, 1, 32'h0000F00D);
        chk("sz11_lsel", ld_l_sel, 2'b10);
        chk("sz11_raw", ld_raw_data, 32'h0000F00D);
        idle_cycle("sz11");

        // LW with no response: 8 WAIT cycles then bus_err
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, -1, 32'h0);
        chk("to_done_c", done_c, 10);
        chk("to_berr", bus_err, 1'b1);
        chk("to_raw", ld_raw_data, 32'h0);
        chk("to_stalls", n_stall, 10);
        idle_cycle("to");

        // Response on the 8th WAIT cycle wins
        access(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1, 9, 32'h0BADF00D);
        chk("late_done_c", done_c, 10);
        chk("late_berr", bus_err, 1'b0);
        chk("late_raw", ld_raw_data, 32'h0BADF00D);
        idle_cycle("late");

        // Reset during WAIT, then a stray response
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_req          = 1'b1;
            mem_we           = 1'b0;
            mem_size         = 2'b10;
            mem_addr         = 32'h40;
            dm_bus.dm_gnt    = (c == 1);
            dm_bus.dm_rvalid = 1'b0;
            if (c == 3) rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n            = 1'b1;
        mem_req          = 1'b0;
        dm_bus.dm_rvalid = 1'b1;
        dm_bus.dm_rdata  = 32'h11111111;
        #1;
        chk("mrst_ctrl", {28'd0, stall, done, misalign_err, bus_err}, 32'd0);
        chk("mrst_dm", {27'd0, dm_bus.dm_req, dm_bus.dm_be}, 32'd0);
        chk("mrst_addr", dm_bus.dm_addr, 32'd0);
        chk("mrst_ld", {27'd0, ld_l_sel, ld_bhw_sel, ld_u_load}, 32'd0);
        @(negedge clk);
        #1;
        chk("mrst_nodone", done, 1'b0);
        chk("mrst_raw", ld_raw_data, 32'd0);
        dm_bus.dm_rvalid = 1'b0;

        access(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1, 1, 32'hCAFEF00D);
        chk("post_done_c", done_c, 2);
        chk("post_raw", ld_raw_data, 32'hCAFEF00D);
        chk("post_addr", dm_bus.dm_addr, 32'h104);
        idle_cycle("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
